// File: rtl/jk_excitation_counter.sv
// Loadable up/down counter built from JK flip-flops.
// J/K drive is decoded from the wanted next state through the JK excitation table.
// A sticky self-check compares the JK characteristic result against that wanted state.
module jk_excitation_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] jk_next;
    logic             check_fail;

    // Wanted next state: load beats count, count beats hold
    always_comb begin
        next_state = Q;
        if (load) begin
            next_state = D;
        end else if (en) begin
            if (up) begin
                next_state = Q + ONE;
            end else begin
                next_state = Q - ONE;
            end
        end
    end

    // Excitation table with don't-cares resolved to 0, so J=K=1 never occurs
    always_comb begin
        J = ~Q & next_state;
        K = Q & ~next_state;
    end

    // JK characteristic equation; this is the only path into the state register
    always_comb begin
        jk_next    = (J & ~Q) | (~K & Q);
        check_fail = (jk_next != next_state);
    end

    // Terminal count flags the cycle whose edge wraps the counter
    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            tc = up ? (Q == ALL_ONES) : (Q == '0);
        end
    end

    // State register: one JK flip-flop per bit
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            Q <= '0;
        end else begin
            Q <= jk_next;
        end
    end

    // Sticky excitation-check failure; only reset clears it
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (check_fail) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Self-checking bench for jk_excitation_counter against an arithmetic reference model.
module tb_jk_excitation_counter;

    localparam int unsigned W   = 4;
    localparam int          MOD = 16;

    logic         Clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         tc;
    logic         err;

    int errors;
    int checks;
    int model_q;

    jk_excitation_counter #(.WIDTH(W)) dut (
        .Clk  (Clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .D    (D),
        .Q    (Q),
        .J    (J),
        .K    (K),
        .tc   (tc),
        .err  (err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference next state from the selection rules, plain modular arithmetic
    function automatic int model_next(input int q);
        if (load)      return int'(D);
        else if (en)   return up ? (q + 1) % MOD : (q + MOD - 1) % MOD;
        else           return q;
    endfunction

    // Bits that must rise (J) or fall (K) going from q to n
    function automatic logic [W-1:0] model_j(input int q, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < int'(W); b++)
            if (((q >> b) % 2 == 0) && ((n >> b) % 2 == 1)) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] model_k(input int q, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < int'(W); b++)
            if (((q >> b) % 2 == 1) && ((n >> b) % 2 == 0)) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic model_tc(input int q);
        if (!en || load) return 1'b0;
        return up ? (q == MOD - 1) : (q == 0);
    endfunction

    // Advance one edge, updating the model from inputs sampled at that edge
    task automatic clk_step();
        int n;
        n = model_next(model_q);
        @(posedge Clk);
        #1;
        model_q = n;
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        en   = 1'b0;
        D    = W'(v);
        clk_step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; D = '0;
        #2 rst = 1'b0;
        #1;
        model_q = 0;
        checks++;
        if (Q !== W'(0)) begin errors++; $display("FAIL reset_q got=%0d exp=0", Q); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++;
        if (J !== W'(0) || K !== W'(0) || tc !== 1'b0) begin
            errors++; $display("FAIL reset_comb got J=%b K=%b tc=%b exp 0/0/0", J, K, tc);
        end
        @(negedge Clk);
        rst = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1; load = 1'b0;
        #1;
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (Q !== W'(model_q)) begin errors++; $display("FAIL up_q step=%0d got=%0d exp=%0d", i, Q, model_q); end
            checks++;
            if (tc !== (model_q == MOD - 1)) begin errors++; $display("FAIL up_tc q=%0d got=%b exp=%b", model_q, tc, model_q == MOD - 1); end
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL up_err got=%b exp=0", err); end
            clk_step();
        end
        checks++;
        if (Q !== W'(2)) begin errors++; $display("FAIL up_final got=%0d exp=2", Q); end
    endtask

    task automatic test_load_down();
        do_load(10);
        up = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (Q !== W'(10)) begin errors++; $display("FAIL load_q got=%0d exp=10", Q); end
        checks++;
        if (J !== 4'b0001) begin errors++; $display("FAIL down_j got=%b exp=0001", J); end
        checks++;
        if (K !== 4'b0010) begin errors++; $display("FAIL down_k got=%b exp=0010", K); end
        for (int i = 1; i <= 3; i++) begin
            clk_step();
            checks++;
            if (Q !== W'(10 - i)) begin errors++; $display("FAIL down_q got=%0d exp=%0d", Q, 10 - i); end
        end
    endtask

    task automatic test_wrap_down();
        do_load(0);
        up = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin errors++; $display("FAIL wrap_tc got=%b exp=1", tc); end
        clk_step();
        checks++;
        if (Q !== W'(15)) begin errors++; $display("FAIL wrap_q got=%0d exp=15", Q); end
    endtask

    task automatic test_load_priority();
        do_load(3);
        load = 1'b1; en = 1'b1; up = 1'b1; D = 4'b0101;
        #1;
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL prio_tc got=%b exp=0", tc); end
        clk_step();
        load = 1'b0;
        checks++;
        if (Q !== W'(5)) begin errors++; $display("FAIL prio_q got=%0d exp=5", Q); end
    endtask

    task automatic test_reset_mid();
        do_load(6);
        en = 1'b1; up = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_q = 0;
        checks++;
        if (Q !== W'(0)) begin errors++; $display("FAIL midrst_q got=%0d exp=0", Q); end
        #1 rst = 1'b1;
        clk_step();
        checks++;
        if (Q !== W'(1)) begin errors++; $display("FAIL resume_q got=%0d exp=1", Q); end
        @(posedge Clk);
        rst = 1'b0;
        #1;
        model_q = 0;
        checks++;
        if (Q !== W'(0)) begin errors++; $display("FAIL edgerst_q got=%0d exp=0", Q); end
        @(negedge Clk);
        rst = 1'b1;
        #1;
        clk_step();
        checks++;
        if (Q !== W'(1)) begin errors++; $display("FAIL edgerst_resume got=%0d exp=1", Q); end
    endtask

    task automatic test_hold();
        do_load(9);
        en = 1'b0; load = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Q !== W'(9) || J !== W'(0) || K !== W'(0)) begin
                errors++; $display("FAIL hold got Q=%0d J=%b K=%b exp 9/0000/0000", Q, J, K);
            end
            clk_step();
        end
        checks++;
        if (Q !== W'(9)) begin errors++; $display("FAIL hold_final got=%0d exp=9", Q); end
    endtask

    task automatic test_random();
        int n;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom);
            D    = W'($urandom);
            #1;
            n = model_next(model_q);
            checks++;
            if (J !== model_j(model_q, n) || K !== model_k(model_q, n) || tc !== model_tc(model_q)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_comb q=%0d got J=%b K=%b tc=%b exp J=%b K=%b tc=%b",
                    model_q, J, K, tc, model_j(model_q, n), model_k(model_q, n), model_tc(model_q));
            end
            clk_step();
            checks++;
            if (Q !== W'(model_q) || err !== 1'b0) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_q got Q=%0d err=%b exp Q=%0d err=0", Q, err, model_q);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_q = 0;
        test_reset();
        test_count_up();
        test_load_down();
        test_wrap_down();
        test_load_priority();
        test_reset_mid();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
